// File: rtl/mul_acc.sv
// mul_acc: rebuilds num = quo*denom + rem by repeated addition of the fixed
// divisor, one add per clock, behind a start/busy/done handshake.
module mul_acc #(
  parameter int unsigned denom = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] quo,
  input  logic [6:0] rem,
  output logic [6:0] num,
  output logic       busy,
  output logic       done,
  output logic       ovf,
  output logic       rem_err
);

  localparam logic [7:0] ADDEND = 8'(denom);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state;
  logic [7:0] acc;
  logic [3:0] cnt;
  logic       ovf_next;
  logic       rem_err_next;

  // True when acc + b leaves the 7-bit result range (bit 7 set or carry out).
  function automatic logic add_ovf(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8] | s[7];
  endfunction

  // Seed check: a remainder at or above the divisor is not a canonical pair.
  function automatic logic seed_bad(input logic [6:0] r);
    return {1'b0, r} >= ADDEND;
  endfunction

  // Control FSM plus accumulator; every output is registered here.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      acc          <= '0;
      cnt          <= '0;
      num          <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      ovf          <= 1'b0;
      rem_err      <= 1'b0;
      ovf_next     <= 1'b0;
      rem_err_next <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          // DONE accepts start like IDLE so back-to-back ops have no gap.
          if (start) begin
            acc          <= {1'b0, rem};
            cnt          <= quo;
            rem_err_next <= seed_bad(rem);
            ovf_next     <= 1'b0;
            busy         <= 1'b1;
            state        <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          if (cnt != 4'd0) begin
            acc      <= acc + ADDEND;
            ovf_next <= ovf_next | add_ovf(acc, ADDEND);
            cnt      <= cnt - 4'd1;
          end else begin
            num     <= acc[6:0];
            ovf     <= ovf_next;
            rem_err <= rem_err_next;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_acc.sv
// Bench for mul_acc: two instances (denom 5 and 9) share stimulus; expected
// results go into per-instance queues and a monitor pops them on done.
module tb_mul_acc;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] quo;
  logic [6:0] rem;

  logic [6:0] num5, num9;
  logic       busy5, busy9, done5, done9, ovf5, ovf9, rerr5, rerr9;

  int checks;
  int failures;
  int cyc;

  typedef struct {
    int num;
    int ovf;
    int rem_err;
    int due;
  } exp_t;

  exp_t exp5[$];
  exp_t exp9[$];

  mul_acc #(.denom(5)) dut5 (
    .clk(clk), .reset(reset), .start(start), .quo(quo), .rem(rem),
    .num(num5), .busy(busy5), .done(done5), .ovf(ovf5), .rem_err(rerr5)
  );

  mul_acc #(.denom(9)) dut9 (
    .clk(clk), .reset(reset), .start(start), .quo(quo), .rem(rem),
    .num(num9), .busy(busy9), .done(done9), .ovf(ovf9), .rem_err(rerr9)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain arithmetic on the dividend.
  function automatic exp_t model(input int q, input int r, input int d, input int due);
    exp_t e;
    int full;
    full      = q * d + r;
    e.num     = full % 128;
    e.ovf     = (full > 127) ? 1 : 0;
    e.rem_err = (r >= d) ? 1 : 0;
    e.due     = due;
    return e;
  endfunction

  // Monitor for the denom=5 instance.
  always @(negedge clk) begin
    if (reset) begin
      if (busy5 && done5) chk("overlap5", 1, 0);
      if (done5) begin
        if (exp5.size() == 0) chk("extra_done5", 1, 0);
        else begin
          exp_t e;
          e = exp5.pop_front();
          chk("num5", int'(num5), e.num);
          chk("ovf5", int'(ovf5), e.ovf);
          chk("rem_err5", int'(rerr5), e.rem_err);
          chk("latency5", cyc, e.due);
        end
      end
    end
  end

  // Monitor for the denom=9 instance.
  always @(negedge clk) begin
    if (reset) begin
      if (busy9 && done9) chk("overlap9", 1, 0);
      if (done9) begin
        if (exp9.size() == 0) chk("extra_done9", 1, 0);
        else begin
          exp_t e;
          e = exp9.pop_front();
          chk("num9", int'(num9), e.num);
          chk("ovf9", int'(ovf9), e.ovf);
          chk("rem_err9", int'(rerr9), e.rem_err);
          chk("latency9", cyc, e.due);
        end
      end
    end
  end

  // Called #1 after a posedge with the DUT in IDLE or DONE; returns #1 after
  // the edge that produces done. Operands and start are scrambled during RUN.
  task automatic issue(input int q, input int r);
    start = 1'b1;
    quo   = 4'(q);
    rem   = 7'(r);
    exp5.push_back(model(q, r, 5, cyc + q + 2));
    exp9.push_back(model(q, r, 9, cyc + q + 2));
    @(posedge clk); #1;
    for (int i = 0; i <= q; i++) begin
      start = 1'($urandom);
      quo   = 4'($urandom);
      rem   = 7'($urandom);
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_num5"}, int'(num5), 0);
    chk({tag, "_busy5"}, int'(busy5), 0);
    chk({tag, "_done5"}, int'(done5), 0);
    chk({tag, "_ovf5"}, int'(ovf5), 0);
    chk({tag, "_rerr5"}, int'(rerr5), 0);
    chk({tag, "_num9"}, int'(num9), 0);
    chk({tag, "_ovf9"}, int'(ovf9), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    reset    = 1'b0;
    start    = 1'b0;
    quo      = '0;
    rem      = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    reset = 1'b1;
    idle(2);

    // Directed cases.
    issue(3, 2);            // d5: 17
    idle(1);
    issue(0, 4);            // d5: 4
    issue(15, 4);           // back-to-back, d5: 79
    idle(2);
    issue(15, 8);           // d9: 143 -> 15, ovf
    issue(1, 0);            // d9: 9, ovf clears
    idle(1);
    issue(2, 6);            // d5: 16, rem_err
    idle(2);

    // Reset mid-RUN discards the operation.
    start = 1'b1; quo = 4'd10; rem = 7'd1;
    @(posedge clk); #1;     // edge S
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    @(posedge clk); #1;     // edge S+4 under reset
    chk_zero("midrun");
    reset = 1'b1;
    idle(15);
    issue(1, 1);            // d5: 6
    idle(2);

    // Reset held while start is asserted.
    reset = 1'b0;
    start = 1'b1;
    quo   = 4'd2;
    rem   = 7'd3;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("hold_busy5", int'(busy5), 0);
      chk("hold_done5", int'(done5), 0);
    end
    reset = 1'b1;
    start = 1'b0;
    idle(2);
    issue(4, 3);

    // Randomized operations with random gaps or back-to-back starts.
    for (int n = 0; n < 40; n++) begin
      int q, r;
      q = $urandom_range(0, 15);
      r = $urandom_range(0, 127);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
      issue(q, r);
    end

    idle(20);
    chk("pending5", exp5.size(), 0);
    chk("pending9", exp9.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_acc.md
# mul_acc

Sequential multiply-accumulate reconstructor, the inverse of the team's repeated-subtraction divider. It takes a quotient and remainder for a fixed divisor `denom` and rebuilds the dividend `num = quo*denom + rem` by repeated addition, one add per clock. The block sits downstream of the divider: it round-trip-checks divider results and regenerates tick counts from stored quotient/remainder pairs. A start/busy/done handshake wraps the operation.

## Interface
- `denom`, default 5: fixed divisor (addend); legal range 1..127.
- `clk`, input, 1: system clock; all state changes on its rising edge.
- `reset`, input, 1: synchronous, active-low reset; sampled on rising `clk`.
- `start`, input, 1: request; sampled only when `busy`=0.
- `quo`, input, 4: quotient operand (number of additions, 0..15).
- `rem`, input, 7: remainder operand (accumulator seed).
- `num`, output, 7: reconstructed value; holds last result until the next completion.
- `busy`, output, 1: high while in RUN.
- `done`, output, 1: one-cycle pulse when `num` is updated.
- `ovf`, output, 1: result exceeded 127; valid with `done`, held with `num`.
- `rem_err`, output, 1: captured `rem` was >= `denom`; valid with `done`, held with `num`.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - `start`=1 → load `acc` (8-bit) = {0,`rem`} and `cnt` = `quo`.
  - Capture `rem_err_next` = (`rem` >= `denom`).
  - Go to RUN.
- RUN:
  - `cnt` != 0: `acc` <= `acc` + `denom` (8-bit add, wraps mod 256); set sticky internal `ovf_next` if the 8-bit sum exceeds 127 or carries out of bit 7; `cnt` <= `cnt` - 1; stay in RUN.
  - `cnt` == 0: `num` <= `acc[6:0]`, `ovf` <= `ovf_next`, `rem_err` <= `rem_err_next`; go to DONE.
- DONE:
  - `done`=1 for exactly this cycle.
  - `start`=1 here is accepted exactly as in IDLE and goes to RUN, so back-to-back operation has no idle gap.
  - Otherwise go to IDLE.
- `start` in RUN is ignored; the operand inputs are not re-sampled.
- Overflow: `num` is the low 7 bits of the true result; `ovf`=1 flags the truncation. The operation is never aborted.
- `rem_err` is informational only; the computation proceeds with the given `rem`.
- `quo`=0: no additions are performed; `num` = `rem`.

## Timing
- Reset values (`reset`=0 at a rising edge): state=IDLE; `acc`, `cnt`, `num` = 0; `busy`, `done`, `ovf`, `rem_err` = 0; internal sticky flags cleared.
- Reset has priority over every other condition, including mid-RUN and the DONE cycle. An in-flight result is discarded and `num` reads 0.
- Call the rising edge that samples `start` edge S.
  - `busy`=1 from S+0 (after edge S) through the RUN cycles.
  - Additions occur at edges S+1 .. S+`quo`.
  - `num`, `ovf`, `rem_err` update and `done` rises after edge S+`quo`+1.
  - Latency, start to `done`, is `quo`+1 cycles: 1 for `quo`=0, 16 for `quo`=15.
- `busy` is 0 in IDLE and DONE.
- `done` and `busy` are never high together.
- Outputs are registered; there is no combinational path from the inputs.

## Test plan
- `denom`=5, `quo`=3, `rem`=2, `start` pulse → `busy` for 4 cycles; `done` after edge S+4; `num`=17, `ovf`=0, `rem_err`=0.
- `denom`=5, `quo`=0, `rem`=4 → `done` after edge S+1; `num`=4. Then `quo`=15, `rem`=4, with `start` held in the DONE cycle → immediate restart; `done` 16 cycles later with `num`=79.
- `denom`=9, `quo`=15, `rem`=8 (true result 143) → `num`=15, `ovf`=1. The next operation `quo`=1, `rem`=0 → `num`=9, `ovf`=0 (flag not sticky across operations).
- `denom`=5, `quo`=2, `rem`=6 → `num`=16, `rem_err`=1. Toggle `start` and change `quo`/`rem` while `busy` → result unchanged, no extra `done`.
- Start `quo`=10, `rem`=1; drive `reset`=0 for one edge at S+4 → all outputs 0, state IDLE, no `done`. A fresh start with `quo`=1, `rem`=1 → `num`=6.
- Hold `reset`=0 while `start`=1 for 3 edges → `busy`, `done` stay 0. Release → IDLE; next `start` behaves normally.
